// File: rtl/poly_sweep_driver_pkg.sv
// Shared constants for the quadratic-solver sweep driver.
// State codes, datapath widths and the sweep step helper.
package poly_sweep_driver_pkg;

  localparam int X_W = 8;
  localparam int D_W = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  // Two guard bits so cur_x + step never wraps before the range check.
  function automatic logic signed [X_W+1:0] sweep_next(
    input logic signed [X_W-1:0] x,
    input logic        [X_W-1:0] step
  );
    return $signed({{2{x[X_W-1]}}, x}) + $signed({2'b00, step});
  endfunction

endpackage

// File: rtl/poly_sweep_driver_timeout.sv
// Cycle counter that flags a solver request left unanswered too long.
// clear restarts the count; enable adds the current cycle.
module sweep_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= W'(enable);
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/poly_sweep_driver.sv
// Sweeps x over a range, issuing one quadratic-solver request per point
// and handing each result downstream through a one-entry output register.
module poly_sweep_driver
  import poly_sweep_driver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic [X_W-1:0]   x_first,
  input  logic [X_W-1:0]   x_last,
  input  logic [X_W-1:0]   x_step,
  input  logic [D_W-1:0]   coef_a,
  input  logic [D_W-1:0]   coef_b,
  input  logic [D_W-1:0]   coef_c,
  output logic             s_start,
  output logic [X_W-1:0]   s_x,
  output logic [D_W-1:0]   s_a,
  output logic [D_W-1:0]   s_b,
  output logic [D_W-1:0]   s_c,
  input  logic             s_ready,
  input  logic             s_valid,
  input  logic [D_W-1:0]   s_result,
  output logic             out_valid,
  input  logic             out_ack,
  output logic [D_W-1:0]   out_data,
  output logic [X_W-1:0]   out_x,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] count
);

  logic [2:0] state;
  logic signed [X_W-1:0] cur_x;
  logic signed [X_W-1:0] last_x;
  logic [X_W-1:0] step;
  logic signed [X_W+1:0] next_x;
  logic reg_free;
  logic launch;
  logic capture;
  logic expired;
  logic finish;

  assign reg_free = !out_valid || out_ack;
  assign launch   = (state == ST_ISSUE) && s_ready && reg_free;
  assign capture  = (state == ST_WAIT) && s_valid;
  assign next_x   = sweep_next(cur_x, step);
  assign finish   = (step == '0) || (next_x > last_x)
                 || (next_x > 10'sd127);

  assign s_start = launch;
  assign s_x     = cur_x;
  assign busy    = (state == ST_ISSUE) || (state == ST_WAIT)
                || (state == ST_DONE);
  assign done    = (state == ST_DONE) && reg_free;

  sweep_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clock  (clock),
    .reset  (reset),
    .clear  (launch),
    .enable (launch || (state == ST_WAIT)),
    .expired(expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cur_x     <= '0;
      last_x    <= '0;
      step      <= '0;
      s_a       <= '0;
      s_b       <= '0;
      s_c       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_x     <= '0;
      count     <= '0;
      error     <= 1'b0;
    end else begin
      if (capture) begin
        out_valid <= 1'b1;
        out_data  <= s_result;
        out_x     <= cur_x;
        if (count != '1) count <= count + 1'b1;
      end else if (out_ack) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE, ST_ERROR: begin
          if (go) begin
            cur_x  <= x_first;
            last_x <= x_last;
            step   <= x_step;
            s_a    <= coef_a;
            s_b    <= coef_b;
            s_c    <= coef_c;
            count  <= '0;
            error  <= 1'b0;
            if ($signed(x_first) > $signed(x_last)) state <= ST_DONE;
            else state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (launch) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (s_valid) begin
            if (finish) begin
              state <= ST_DONE;
            end else begin
              cur_x <= next_x[X_W-1:0];
              state <= ST_ISSUE;
            end
          end else if (expired) begin
            error <= 1'b1;
            state <= ST_ERROR;
          end
        end
        ST_DONE: begin
          if (reg_free) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_sweep_driver.sv
// Bench for poly_sweep_driver: a latency-programmable solver model,
// a downstream ack agent and an arithmetic reference of the sweep.
module tb_poly_sweep_driver;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic [7:0]  x_first = '0, x_last = '0, x_step = '0;
  logic [15:0] coef_a = '0, coef_b = '0, coef_c = '0;
  logic        s_start;
  logic [7:0]  s_x;
  logic [15:0] s_a, s_b, s_c;
  logic        s_ready = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_result = '0;
  logic        out_valid;
  logic        out_ack = 1'b0;
  logic [15:0] out_data;
  logic [7:0]  out_x;
  logic        busy, done, error;
  logic [8:0]  count;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  poly_sweep_driver #(.TIMEOUT_CYCLES(64), .CNT_W(9)) dut (
    .clock(clock), .reset(reset), .go(go),
    .x_first(x_first), .x_last(x_last), .x_step(x_step),
    .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c),
    .s_start(s_start), .s_x(s_x),
    .s_a(s_a), .s_b(s_b), .s_c(s_c),
    .s_ready(s_ready), .s_valid(s_valid), .s_result(s_result),
    .out_valid(out_valid), .out_ack(out_ack),
    .out_data(out_data), .out_x(out_x),
    .busy(busy), .done(done), .error(error), .count(count)
  );

  // agent knobs, written only by the test tasks
  bit solver_en = 1'b1;
  int lat = 3;
  int ack_mode = 0;
  int late_req = 0;

  // agent state, written only by the agent
  bit pend = 1'b0;
  int wcnt = 0;
  int late_seen = 0;
  int px, pa, pb, pc;
  int n_start = 0;
  int n_done = 0;
  logic [7:0]  got_x[$];
  logic [15:0] got_d[$];

  // drive at the falling edge, then sample once everything settled
  always @(negedge clock) begin
    s_valid = 1'b0;
    if (!reset) pend = 1'b0;
    if (late_req != late_seen) begin
      late_seen = late_req;
      s_valid = 1'b1;
      s_result = 16'h7777;
    end else if (pend) begin
      wcnt--;
      if (wcnt <= 0) begin
        s_valid = 1'b1;
        s_result = 16'(pa * px * px + pb * px + pc);
        pend = 1'b0;
      end
    end
    s_ready = !pend;
    case (ack_mode)
      0: out_ack = 1'b1;
      1: out_ack = 1'($urandom_range(0, 1));
      default: out_ack = 1'b0;
    endcase
    #1;
    if (s_start) begin
      n_start++;
      if (solver_en) begin
        pend = 1'b1;
        wcnt = lat;
        px = int'($signed(s_x));
        pa = int'($signed(s_a));
        pb = int'($signed(s_b));
        pc = int'($signed(s_c));
      end
    end
    if (out_valid && out_ack) begin
      got_x.push_back(out_x);
      got_d.push_back(out_data);
    end
    if (done) n_done++;
  end

  logic [7:0]  exp_x[$];
  logic [15:0] exp_d[$];
  int st_base, dn_base, g_base;
  logic err_after, busy_after;

  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  // every x from first while x <= last and x fits in 8 bits signed
  task automatic model_sweep(input int first, input int last,
                             input int stp, input int a,
                             input int b, input int c);
    int x;
    exp_x.delete();
    exp_d.delete();
    x = first;
    while (x <= last && x <= 127) begin
      exp_x.push_back(8'(x));
      exp_d.push_back(16'(a * x * x + b * x + c));
      if (stp == 0) break;
      x = x + stp;
    end
  endtask

  task automatic run_sweep(input int first, input int last,
                           input int stp, input int a,
                           input int b, input int c,
                           output bit to);
    x_first = 8'(first);
    x_last = 8'(last);
    x_step = 8'(stp);
    coef_a = 16'(a);
    coef_b = 16'(b);
    coef_c = 16'(c);
    st_base = n_start;
    dn_base = n_done;
    g_base = got_d.size();
    go = 1'b1;
    tick();
    go = 1'b0;
    err_after = error;
    busy_after = busy;
    to = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if (n_done != dn_base) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    tick();
    tick();
    model_sweep(first, last, stp, a, b, c);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    total++;
    if ({s_start, out_valid, busy, done, error} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=00000",
               {s_start, out_valid, busy, done, error});
    end
    total++;
    if (count !== 9'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d exp=0", count);
    end
    total++;
    if ({out_data, out_x, s_x, s_a, s_b, s_c} !== 80'd0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0",
               {out_data, out_x, s_x, s_a, s_b, s_c});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_parabola();
    bit to;
    lat = 3;
    ack_mode = 0;
    solver_en = 1'b1;
    run_sweep(-2, 2, 1, 1, 0, 0, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL para_done got=timeout exp=done");
    end
    total++;
    if (got_d.size() - g_base != exp_d.size()) begin
      bad++;
      $display("FAIL para_len got=%0d exp=%0d",
               got_d.size() - g_base, exp_d.size());
    end
    foreach (exp_d[i]) begin
      total++;
      if (got_d[g_base+i] !== exp_d[i] || got_x[g_base+i] !== exp_x[i]) begin
        bad++;
        $display("FAIL para_smp%0d got=%0d@%0d exp=%0d@%0d", i,
                 $signed(got_d[g_base+i]), $signed(got_x[g_base+i]),
                 $signed(exp_d[i]), $signed(exp_x[i]));
      end
    end
    total++;
    if (n_start - st_base != 5 || count !== 9'd5) begin
      bad++;
      $display("FAIL para_cnt got=%0d/%0d exp=5/5",
               n_start - st_base, count);
    end
    total++;
    if (n_done - dn_base != 1 || error !== 1'b0) begin
      bad++;
      $display("FAIL para_end got=%0d/%b exp=1/0",
               n_done - dn_base, error);
    end
  endtask

  task automatic test_overflow();
    bit to;
    lat = 2;
    run_sweep(120, 127, 5, 2, -3, 5, to);
    total++;
    if (to || got_d.size() - g_base != 2) begin
      bad++;
      $display("FAIL ovf_len got=%0d exp=2", got_d.size() - g_base);
    end
    total++;
    if (got_d[g_base] !== 16'd28445 || got_d[g_base+1] !== 16'd30880
        || got_x[g_base] !== 8'd120 || got_x[g_base+1] !== 8'd125) begin
      bad++;
      $display("FAIL ovf_data got=%0d,%0d exp=28445,30880",
               got_d[g_base], got_d[g_base+1]);
    end
    total++;
    if (count !== 9'd2 || n_done - dn_base != 1) begin
      bad++;
      $display("FAIL ovf_cnt got=%0d exp=2", count);
    end
  endtask

  task automatic test_step0_empty();
    bit to;
    int sb;
    run_sweep(3, 3, 0, 1, 1, 1, to);
    total++;
    if (to || n_start - st_base != 1 || count !== 9'd1
        || got_x[g_base] !== 8'd3 || got_d[g_base] !== 16'd13) begin
      bad++;
      $display("FAIL step0 got=%0d starts cnt=%0d exp=1/1",
               n_start - st_base, count);
    end
    x_first = 8'd4;
    x_last = 8'hFC;
    x_step = 8'd1;
    sb = n_start;
    go = 1'b1;
    tick();
    go = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || count !== 9'd0) begin
      bad++;
      $display("FAIL empty_done got=%b%b cnt=%0d exp=11 cnt=0",
               done, busy, count);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL empty_idle got=%b%b exp=00", done, busy);
    end
    repeat (3) tick();
    total++;
    if (n_start != sb) begin
      bad++;
      $display("FAIL empty_start got=%0d exp=0", n_start - sb);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d0;
    int sb, db, gb;
    bit seen;
    lat = 2;
    ack_mode = 2;
    x_first = 8'd0;
    x_last = 8'd3;
    x_step = 8'd1;
    coef_a = 16'd3;
    coef_b = 16'd1;
    coef_c = 16'hFFF9;
    sb = n_start;
    db = n_done;
    gb = got_d.size();
    go = 1'b1;
    tick();
    go = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL bp_first got=no_sample exp=sample");
    end
    d0 = out_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (n_start - sb != 1 || out_valid !== 1'b1 || out_data !== d0) begin
        bad++;
        $display("FAIL bp_hold%0d got=%0d starts v=%b d=%0d exp=1 1 %0d",
                 i, n_start - sb, out_valid, out_data, d0);
      end
    end
    ack_mode = 0;
    tick();
    total++;
    if (n_start - sb != 2) begin
      bad++;
      $display("FAIL bp_resume got=%0d exp=2", n_start - sb);
    end
    for (int i = 0; i < 200 && n_done == db; i++) tick();
    tick();
    model_sweep(0, 3, 1, 3, 1, -7);
    total++;
    if (n_done == db || got_d.size() - gb != exp_d.size()
        || d0 !== 16'hFFF9) begin
      bad++;
      $display("FAIL bp_end got=%0d samples d0=%0d exp=%0d -7",
               got_d.size() - gb, $signed(d0), exp_d.size());
    end
    foreach (exp_d[i]) begin
      total++;
      if (got_d[gb+i] !== exp_d[i] || got_x[gb+i] !== exp_x[i]) begin
        bad++;
        $display("FAIL bp_smp%0d got=%0d exp=%0d", i,
                 $signed(got_d[gb+i]), $signed(exp_d[i]));
      end
    end
  endtask

  task automatic test_timeout();
    int sb, first;
    bit to;
    solver_en = 1'b0;
    ack_mode = 0;
    x_first = 8'd0;
    x_last = 8'd5;
    x_step = 8'd1;
    sb = n_start;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 20 && n_start == sb; i++) tick();
    first = -1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (error === 1'b1) begin
        first = k;
        break;
      end
    end
    total++;
    if (first != 64) begin
      bad++;
      $display("FAIL tmo_delay got=%0d exp=64", first);
    end
    late_req++;
    repeat (10) tick();
    total++;
    if (n_start - sb != 1 || busy !== 1'b0 || error !== 1'b1
        || out_valid !== 1'b0 || count !== 9'd0) begin
      bad++;
      $display("FAIL tmo_hold got=%0d starts b=%b e=%b v=%b exp=1 0 1 0",
               n_start - sb, busy, error, out_valid);
    end
    solver_en = 1'b1;
    lat = 1;
    run_sweep(0, 5, 1, 1, 1, 1, to);
    total++;
    if (err_after !== 1'b0 || busy_after !== 1'b1 || to
        || got_d.size() - g_base != 6) begin
      bad++;
      $display("FAIL tmo_restart got=e%b b%b n=%0d exp=e0 b1 n=6",
               err_after, busy_after, got_d.size() - g_base);
    end
    foreach (exp_d[i]) begin
      total++;
      if (got_d[g_base+i] !== exp_d[i]) begin
        bad++;
        $display("FAIL tmo_smp%0d got=%0d exp=%0d", i,
                 got_d[g_base+i], exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_midsweep();
    int sb;
    bit to;
    lat = 6;
    ack_mode = 0;
    x_first = 8'hFD;
    x_last = 8'd3;
    x_step = 8'd1;
    coef_a = 16'd1;
    coef_b = 16'd2;
    coef_c = 16'd3;
    sb = n_start;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 100 && n_start - sb < 2; i++) tick();
    tick();
    tick();
    total++;
    if (count !== 9'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre got=%0d/%b exp=1/1", count, busy);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({s_start, out_valid, busy, error} !== 4'b0 || count !== 9'd0) begin
      bad++;
      $display("FAIL rst_async got=%b cnt=%0d exp=0000 cnt=0",
               {s_start, out_valid, busy, error}, count);
    end
    tick();
    reset = 1'b1;
    late_req++;
    repeat (3) tick();
    total++;
    if (out_valid !== 1'b0 || count !== 9'd0 || n_start - sb != 2) begin
      bad++;
      $display("FAIL rst_late got=v%b c%0d s%0d exp=v0 c0 s2",
               out_valid, count, n_start - sb);
    end
    lat = 2;
    run_sweep(-3, 3, 1, 1, 2, 3, to);
    total++;
    if (to || count !== 9'd7 || got_d.size() - g_base != 7) begin
      bad++;
      $display("FAIL rst_sweep got=%0d exp=7", count);
    end
    foreach (exp_d[i]) begin
      total++;
      if (got_d[g_base+i] !== exp_d[i] || got_x[g_base+i] !== exp_x[i]) begin
        bad++;
        $display("FAIL rst_smp%0d got=%0d exp=%0d", i,
                 got_d[g_base+i], exp_d[i]);
      end
    end
  endtask

  task automatic test_random();
    int first, last, stp, a, b, c;
    bit to;
    for (int r = 0; r < 8; r++) begin
      lat = int'($urandom_range(1, 4));
      ack_mode = 1;
      first = int'($urandom_range(0, 255)) - 128;
      last = int'($urandom_range(0, 255)) - 128;
      stp = int'($urandom_range(0, 40));
      a = int'($urandom_range(0, 65535)) - 32768;
      b = int'($urandom_range(0, 65535)) - 32768;
      c = int'($urandom_range(0, 65535)) - 32768;
      run_sweep(first, last, stp, a, b, c, to);
      total++;
      if (to || got_d.size() - g_base != exp_d.size()
          || count !== 9'(exp_d.size())
          || n_start - st_base != exp_d.size()) begin
        bad++;
        $display("FAIL rnd%0d_len got=%0d cnt=%0d exp=%0d",
                 r, got_d.size() - g_base, count, exp_d.size());
      end
      foreach (exp_d[i]) begin
        total++;
        if (got_d[g_base+i] !== exp_d[i] || got_x[g_base+i] !== exp_x[i]) begin
          bad++;
          $display("FAIL rnd%0d_smp%0d got=%0d@%0d exp=%0d@%0d", r, i,
                   $signed(got_d[g_base+i]), $signed(got_x[g_base+i]),
                   $signed(exp_d[i]), $signed(exp_x[i]));
        end
      end
      total++;
      if (n_done - dn_base != 1 || error !== 1'b0) begin
        bad++;
        $display("FAIL rnd%0d_end got=%0d/%b exp=1/0",
                 r, n_done - dn_base, error);
      end
    end
  endtask

  initial begin
    test_reset();
    test_parabola();
    test_overflow();
    test_step0_empty();
    test_backpressure();
    test_timeout();
    test_reset_midsweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
